register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file.sv | 37 +++
 tb/tb_register_file.sv | 122 ++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths and op encoding for the register file
package register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 3;

    // Op is {WrEn, RdEn}; 2'b11 is deliberately a no-op, not a write.
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - flat register file with registered read port
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WrEn,
    input  logic                  RdEn,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic [DATA_WIDTH-1:0] RdData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Reset clears every word as well as the read register, so no stale data survives.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            RdData <= '0;
        end else begin
            case ({WrEn, RdEn})
                OP_WRITE: mem[Address] <= WrData;
                OP_READ:  RdData       <= mem[Address];
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

    logic        CLK;
    logic        RST;
    logic        WrEn;
    logic        RdEn;
    logic [2:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData;

    int n_vec;
    int n_err;

    register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WrEn    (WrEn),
        .RdEn    (RdEn),
        .Address (Address),
        .WrData  (WrData),
        .RdData  (RdData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one operation, let one rising edge take it, return 1 time unit after the edge.
    task automatic op(input logic we, input logic re, input logic [2:0] addr, input logic [15:0] data);
        WrEn    = we;
        RdEn    = re;
        Address = addr;
        WrData  = data;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        RST     = 1'b0;
        WrEn    = 1'b0;
        RdEn    = 1'b0;
        Address = '0;
        WrData  = '0;
        #2;
        check_eq("reset_rddata", RdData, 16'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        op(1'b1, 1'b0, 3'd5, 16'd10);
        check_eq("write_holds_rd", RdData, 16'd0);
        op(1'b0, 1'b1, 3'd5, 16'd0);
        check_eq("read_a5", RdData, 16'd10);

        op(1'b1, 1'b0, 3'd3, 16'd14);
        check_eq("write_a3_holds_rd", RdData, 16'd10);
        op(1'b0, 1'b1, 3'd5, 16'd0);
        check_eq("reread_a5", RdData, 16'd10);
        op(1'b0, 1'b1, 3'd3, 16'd0);
        check_eq("read_a3", RdData, 16'd14);

        op(1'b1, 1'b1, 3'd3, 16'd100);
        check_eq("both_en_rd", RdData, 16'd14);
        op(1'b0, 1'b0, 3'd0, 16'd0);
        check_eq("idle_holds_rd", RdData, 16'd14);
        op(1'b0, 1'b1, 3'd3, 16'd0);
        check_eq("both_en_no_write", RdData, 16'd14);

        op(1'b0, 1'b0, 3'd5, 16'd13);
        check_eq("no_en_rd", RdData, 16'd14);
        op(1'b0, 1'b1, 3'd5, 16'd0);
        check_eq("no_en_no_write", RdData, 16'd10);

        // Asynchronous reset between edges, then a write attempted while held.
        WrEn = 1'b0;
        RdEn = 1'b0;
        #3;
        RST = 1'b0;
        #1;
        check_eq("async_reset_rd", RdData, 16'd0);
        op(1'b1, 1'b0, 3'd5, 16'd13);
        check_eq("reset_blocks_write", RdData, 16'd0);
        WrEn = 1'b0;
        RST  = 1'b1;
        op(1'b0, 1'b1, 3'd3, 16'd0);
        check_eq("post_reset_a3", RdData, 16'd0);
        op(1'b0, 1'b1, 3'd5, 16'd0);
        check_eq("post_reset_a5", RdData, 16'd0);

        for (int i = 0; i < 8; i++) begin
            op(1'b1, 1'b0, 3'(i), 16'h1000 + 16'(i));
        end
        check_eq("sweep_write_rd", RdData, 16'd0);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] prev;
            prev = (i == 0) ? 16'd0 : 16'h1000 + 16'(i - 1);
            WrEn    = 1'b0;
            RdEn    = 1'b1;
            Address = 3'(i);
            #1;
            check_eq($sformatf("sweep_pre_%0d", i), RdData, prev);
            @(posedge CLK);
            #1;
            check_eq($sformatf("sweep_rd_%0d", i), RdData, 16'h1000 + 16'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
